// File: rtl/imem_boot_sequencer.sv
// Streams a program image into instruction memory, holds the core in reset
// until the image is committed, then runs it until a PC match or cycle budget.
module imem_boot_sequencer #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          MAX_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [11:0] load_count,
  input  logic [31:0] run_limit,
  input  logic [31:0] halt_pc,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        imem_wr,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_reset,
  input  logic [31:0] cpu_pc,
  output logic        done,
  output logic        error,
  output logic [1:0]  halt_reason,
  output logic [31:0] cycles_run
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMMIT = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [31:0] MAX_W = MAX_WORDS;

  typedef struct packed {
    logic [11:0] count;
    logic [31:0] run_limit;
    logic [31:0] halt_pc;
  } sess_t;

  logic [2:0]  state;
  sess_t       sess;
  logic [11:0] idx;
  logic        xfer;
  logic        start_ok;
  logic        pc_hit;
  logic        lim_hit;
  logic [32:0] cyc_inc;

  assign in_ready = (state == S_LOAD);
  assign xfer     = in_ready && in_valid;
  assign start_ok = (load_count != 12'd0) && ({20'd0, load_count} <= MAX_W);
  assign cyc_inc  = {1'b0, cycles_run} + 33'd1;
  assign pc_hit   = (cpu_pc == sess.halt_pc);
  // Compare at 33 bits so a saturated counter can never alias the budget.
  assign lim_hit  = (sess.run_limit != 32'd0) && (cyc_inc == {1'b0, sess.run_limit});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      sess        <= '0;
      idx         <= '0;
      imem_wr     <= 1'b0;
      imem_addr   <= '0;
      imem_data   <= '0;
      cpu_reset   <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
      halt_reason <= 2'b00;
      cycles_run  <= '0;
    end else begin
      imem_wr <= 1'b0;
      if (abort) begin
        state       <= S_IDLE;
        cpu_reset   <= 1'b1;
        done        <= 1'b0;
        halt_reason <= 2'b00;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (load_start) begin
              if (start_ok) begin
                sess        <= '{count: load_count, run_limit: run_limit, halt_pc: halt_pc};
                idx         <= '0;
                cycles_run  <= '0;
                done        <= 1'b0;
                error       <= 1'b0;
                halt_reason <= 2'b00;
                state       <= S_LOAD;
              end else begin
                error <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (xfer) begin
              imem_wr   <= 1'b1;
              imem_addr <= ADDR_BASE + {18'd0, idx, 2'b00};
              imem_data <= in_data;
              idx       <= idx + 12'd1;
              if (idx == sess.count - 12'd1) state <= S_COMMIT;
            end
          end
          S_COMMIT: begin
            state     <= S_RUN;
            cpu_reset <= 1'b0;
          end
          S_RUN: begin
            cycles_run <= cyc_inc[32] ? cycles_run : cyc_inc[31:0];
            if (pc_hit || lim_hit) begin
              state       <= S_DONE;
              done        <= 1'b1;
              cpu_reset   <= 1'b1;
              halt_reason <= {lim_hit, pc_hit};
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Randomized bench for imem_boot_sequencer; load and run outcomes are predicted
// from word order and the earliest of PC-hit cycle and run budget.
module tb_imem_boot_sequencer;

  logic        clk, reset, load_start, abort, in_valid;
  logic [11:0] load_count;
  logic [31:0] run_limit, halt_pc, in_data, cpu_pc;
  logic        in_ready, imem_wr, cpu_reset, done, error;
  logic [31:0] imem_addr, imem_data, cycles_run;
  logic [1:0]  halt_reason;

  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] cur_hpc;
  logic [31:0] words[$];
  logic [31:0] wa_q[$], wd_q[$];
  int          wc_q[$];

  imem_boot_sequencer dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_count(load_count),
    .run_limit(run_limit), .halt_pc(halt_pc), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_wr(imem_wr), .imem_addr(imem_addr),
    .imem_data(imem_data), .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .done(done),
    .error(error), .halt_reason(halt_reason), .cycles_run(cycles_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Expected run outcome: the earliest of PC-hit cycle and budget ends RUN.
  function automatic void model_run(input int lim, input int hit, output int end_k,
                                    output logic [1:0] hr);
    int e = 0;
    if (hit > 0) e = hit;
    if (lim > 0 && (e == 0 || lim < e)) e = lim;
    end_k = e;
    hr = {(lim > 0 && e == lim), (hit > 0 && e == hit)};
  endfunction

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic start_load(input logic [11:0] cnt, input logic [31:0] lim, input logic [31:0] hpc);
    load_start = 1'b1; load_count = cnt; run_limit = lim; halt_pc = hpc; cur_hpc = hpc;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Drives words[0..n-1] with random gaps; stray load_start pulses must be ignored.
  task automatic feed(input int n, input int gap_pct);
    int sent = 0;
    int got = 0;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    for (int c = 0; c < 20000 && got < n; c++) begin
      if (sent < n && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1; in_data = words[sent]; sent++;
      end else begin
        in_valid = 1'b0; in_data = $urandom;
      end
      load_start = 1'($urandom_range(1)); load_count = 12'($urandom);
      @(negedge clk);
      if (imem_wr) begin
        wa_q.push_back(imem_addr); wd_q.push_back(imem_data); wc_q.push_back(cyc); got++;
      end
    end
    in_valid = 1'b0; load_start = 1'b0;
  endtask

  // Called at the COMMIT negedge; returns the RUN cycle in which done rose (-1 on timeout).
  task automatic run_phase(input int hit_at, output int end_k, output logic rst_in_run);
    end_k = -1;
    cpu_pc = cur_hpc ^ 32'h4;
    @(negedge clk);
    rst_in_run = cpu_reset;
    for (int k = 1; k <= 400; k++) begin
      cpu_pc = (k == hit_at) ? cur_hpc : cur_hpc ^ 32'h4;
      load_start = 1'($urandom_range(1)); load_count = 12'd5;
      @(negedge clk);
      if (done) begin end_k = k; break; end
    end
    load_start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; load_start = 0; abort = 0; in_valid = 0; load_count = 0;
    run_limit = 0; halt_pc = 0; in_data = 0; cpu_pc = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({in_ready, imem_wr, cpu_reset, done, error, halt_reason} !== 7'b0010000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0010000",
        {in_ready, imem_wr, cpu_reset, done, error, halt_reason});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({imem_addr, imem_data, cycles_run} !== 96'd0) begin
      fails++; $display("FAIL reset_data: addr %h data %h cycles %h want 0", imem_addr, imem_data, cycles_run);
    end
    tests++;
    if ({in_ready, cpu_reset} !== 2'b01) begin
      fails++; $display("FAIL reset_idle: in_ready/cpu_reset %b want 01", {in_ready, cpu_reset});
    end
  endtask

  task automatic test_load3;
    int ek; logic rr;
    fill_words(3);
    start_load(12'd3, 32'd0, 32'hDEAD_0000);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL load3_ready: got %b want 1", in_ready); end
    feed(3, 0);
    tests++;
    if (wa_q.size() !== 3) begin fails++; $display("FAIL load3_count: got %0d want 3", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 3; i++) begin
      tests++;
      if (wa_q[i] !== 32'(4 * i) || wd_q[i] !== words[i] || wc_q[i] !== wc_q[0] + i) begin
        fails++; $display("FAIL load3_wr%0d: addr %h data %h cyc %0d want %h %h %0d",
          i, wa_q[i], wd_q[i], wc_q[i], 32'(4 * i), words[i], wc_q[0] + i);
      end
    end
    tests++;
    if (cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL load3_commit: cpu_reset %b in_ready %b want 1 0", cpu_reset, in_ready);
    end
    run_phase(2, ek, rr);
    tests++;
    if (rr !== 1'b0) begin fails++; $display("FAIL load3_release: cpu_reset %b want 0", rr); end
    tests++;
    if (ek !== 2 || halt_reason !== 2'b01) begin
      fails++; $display("FAIL load3_end: cycle %0d hr %b want 2 01", ek, halt_reason);
    end
  endtask

  task automatic test_pc_halt;
    int ek, xk; logic rr; logic [1:0] xhr;
    fill_words(2);
    start_load(12'd2, 32'd0, 32'h8);
    feed(2, 0);
    run_phase(4, ek, rr);
    model_run(0, 4, xk, xhr);
    tests++;
    if (ek !== xk || done !== 1'b1 || halt_reason !== xhr || cycles_run !== 32'(xk) || cpu_reset !== 1'b1) begin
      fails++; $display("FAIL pc_halt: cyc %0d done %b hr %b run %0d rst %b want %0d 1 %b %0d 1",
        ek, done, halt_reason, cycles_run, cpu_reset, xk, xhr, xk);
    end
  endtask

  task automatic test_limit;
    int ek, xk; logic rr; logic [1:0] xhr;
    for (int v = 0; v < 2; v++) begin
      int hit = (v == 0) ? 0 : 5;
      fill_words(1);
      start_load(12'd1, 32'd5, 32'h1234_5670);
      feed(1, 0);
      run_phase(hit, ek, rr);
      model_run(5, hit, xk, xhr);
      tests++;
      if (ek !== xk || halt_reason !== xhr || cycles_run !== 32'(xk) || done !== 1'b1) begin
        fails++; $display("FAIL limit_v%0d: cyc %0d hr %b run %0d done %b want %0d %b %0d 1",
          v, ek, halt_reason, cycles_run, done, xk, xhr, xk);
      end
    end
  endtask

  task automatic test_errors;
    int ek; logic rr;
    start_load(12'd0, 32'd0, 32'h0);
    tests++;
    if (error !== 1'b1 || done !== 1'b1 || halt_reason !== 2'b11 || in_ready !== 1'b0 || cycles_run !== 32'd5) begin
      fails++; $display("FAIL err_zero: err %b done %b hr %b rdy %b run %0d want 1 1 11 0 5",
        error, done, halt_reason, in_ready, cycles_run);
    end
    fill_words(1);
    start_load(12'd1, 32'd0, 32'h20);
    tests++;
    if (error !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || halt_reason !== 2'b00 || cycles_run !== 32'd0) begin
      fails++; $display("FAIL err_clear: err %b rdy %b done %b hr %b run %0d want 0 1 0 00 0",
        error, in_ready, done, halt_reason, cycles_run);
    end
    feed(1, 0);
    run_phase(1, ek, rr);
    abort = 1'b1; load_start = 1'b1; load_count = 12'd4;
    @(negedge clk);
    abort = 1'b0; load_start = 1'b0;
    tests++;
    if (in_ready !== 1'b0 || done !== 1'b0 || halt_reason !== 2'b00 || cycles_run !== 32'd1 || cpu_reset !== 1'b1) begin
      fails++; $display("FAIL abort_done: rdy %b done %b hr %b run %0d rst %b want 0 0 00 1 1",
        in_ready, done, halt_reason, cycles_run, cpu_reset);
    end
    start_load(12'd2049, 32'd0, 32'h0);
    tests++;
    if (error !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL err_big: err %b rdy %b done %b want 1 0 0", error, in_ready, done);
    end
  endtask

  task automatic test_abort;
    fill_words(3);
    start_load(12'd3, 32'd0, 32'h100);
    tests++;
    if (error !== 1'b0) begin fails++; $display("FAIL abort_start: err %b want 0", error); end
    in_valid = 1'b1; in_data = words[0];
    @(negedge clk);
    tests++;
    if (imem_wr !== 1'b1 || imem_addr !== 32'd0 || imem_data !== words[0]) begin
      fails++; $display("FAIL abort_w0: wr %b addr %h data %h want 1 0 %h", imem_wr, imem_addr, imem_data, words[0]);
    end
    in_data = words[1]; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    tests++;
    if (imem_wr !== 1'b0 || in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0 || halt_reason !== 2'b00) begin
      fails++; $display("FAIL abort_idle: wr %b rdy %b rst %b done %b hr %b want 0 0 1 0 00",
        imem_wr, in_ready, cpu_reset, done, halt_reason);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (imem_wr !== 1'b0) begin fails++; $display("FAIL abort_quiet%0d: wr %b want 0", i, imem_wr); end
    end
  endtask

  task automatic test_max;
    int ek; logic rr; int bad = 0;
    fill_words(2048);
    start_load(12'd2048, 32'd3, 32'hFFFF_FFF0);
    tests++;
    if (in_ready !== 1'b1 || error !== 1'b0) begin
      fails++; $display("FAIL max_accept: rdy %b err %b want 1 0", in_ready, error);
    end
    feed(2048, 0);
    for (int i = 0; i < wa_q.size(); i++)
      if (wa_q[i] !== 32'(4 * i) || wd_q[i] !== words[i]) bad++;
    tests++;
    if (wa_q.size() !== 2048 || bad !== 0) begin
      fails++; $display("FAIL max_writes: count %0d bad %0d want 2048 0", wa_q.size(), bad);
    end
    run_phase(0, ek, rr);
    tests++;
    if (ek !== 3 || halt_reason !== 2'b10) begin
      fails++; $display("FAIL max_run: cyc %0d hr %b want 3 10", ek, halt_reason);
    end
  endtask

  task automatic test_random;
    for (int s = 0; s < 10; s++) begin
      int n, lim, hit, ek, xk; logic rr; logic [1:0] xhr;
      n = $urandom_range(1, 16);
      lim = $urandom_range(0, 20);
      hit = $urandom_range(0, 20);
      if (lim == 0 && hit == 0) hit = 7;
      fill_words(n);
      start_load(12'(n), 32'(lim), $urandom & 32'hFFFF_FFF0);
      feed(n, 30);
      tests++;
      if (wa_q.size() !== n) begin
        fails++; $display("FAIL rnd%0d_count: got %0d want %0d", s, wa_q.size(), n);
      end
      for (int i = 0; i < wa_q.size() && i < n; i++) begin
        tests++;
        if (wa_q[i] !== 32'(4 * i) || wd_q[i] !== words[i]) begin
          fails++; $display("FAIL rnd%0d_wr%0d: addr %h data %h want %h %h", s, i, wa_q[i], wd_q[i], 32'(4 * i), words[i]);
        end
      end
      run_phase(hit, ek, rr);
      model_run(lim, hit, xk, xhr);
      tests++;
      if (ek !== xk || halt_reason !== xhr || cycles_run !== 32'(xk) || rr !== 1'b0 || error !== 1'b0) begin
        fails++; $display("FAIL rnd%0d_run: cyc %0d hr %b run %0d rst %b err %b want %0d %b %0d 0 0",
          s, ek, halt_reason, cycles_run, rr, error, xk, xhr, xk);
      end
    end
  endtask

  task automatic test_async_reset;
    fill_words(4);
    start_load(12'd4, 32'd0, 32'h40);
    feed(4, 0);
    cpu_pc = 32'h44;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({in_ready, imem_wr, cpu_reset, done, error, halt_reason} !== 7'b0010000 ||
        {imem_addr, imem_data, cycles_run} !== 96'd0) begin
      fails++; $display("FAIL arst_run: ctrl %b addr %h data %h run %0d want 0010000 0 0 0",
        {in_ready, imem_wr, cpu_reset, done, error, halt_reason}, imem_addr, imem_data, cycles_run);
    end
    @(negedge clk);
    reset = 1'b0;
    fill_words(3);
    start_load(12'd3, 32'd0, 32'h40);
    in_valid = 1'b1; in_data = words[0];
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    tests++;
    if (imem_wr !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL arst_load: wr %b rdy %b want 0 0", imem_wr, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (imem_wr !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL arst_quiet%0d: wr %b rdy %b want 0 0", i, imem_wr, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load3();
    test_pc_halt();
    test_limit();
    test_errors();
    test_abort();
    test_max();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
